// File: rtl/serial_word_packer.sv
// Serial-to-parallel packer: collects bits over valid/ready and presents N-bit words
// with a registered load strobe that can be stalled by out_ready.
module serial_word_packer #(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 clr,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N-1:0]         out_word,
  output logic                 out_load,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] bit_cnt,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [N-1:0]  word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q, load_d;
  logic [N-1:0]  shifted;
  logic          accept;
  logic          xfer;

  // out_ready -> in_ready is the only combinational path through the block.
  assign in_ready = (state_q != HOLD) | out_ready;
  assign accept   = in_valid & in_ready;
  assign xfer     = load_q & out_ready;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sr_q[N-2:0], in_bit};
    end else begin
      shifted = {in_bit, sr_q[N-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    if (clr) begin
      state_d = IDLE;
      sr_d    = '0;
      word_d  = '0;
      cnt_d   = '0;
      load_d  = 1'b0;
    end else begin
      if (xfer) begin
        load_d  = 1'b0;
        state_d = IDLE;
      end
      // An accept in HOLD only happens alongside a transfer, so it starts the next word.
      if (accept) begin
        sr_d = shifted;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          word_d  = shifted;
          load_d  = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = SHIFT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q <= IDLE;
      sr_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  assign out_word = word_q;
  assign out_load = load_q;
  assign bit_cnt  = cnt_q;
  assign busy     = (state_q != IDLE);

endmodule
